// File: rtl/maddu_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: instruction codes and the
// multiply state encoding.
package maddu_sequencer_pkg;

    localparam logic [5:0] OP_SPECIAL2 = 6'd28;
    localparam logic [5:0] FUNCT_MADDU = 6'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/maddu_sequencer_mul_dp.sv
// Iterative shift-add unsigned multiplier datapath: one multiplier bit per step,
// product complete after WIDTH steps.
module maddu_sequencer_mul_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o,
    output logic               last_step_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] p_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH:0]     sum_d;

    // Carry out of the upper half is kept and shifted back into bit 2W-1.
    assign sum_d = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            count_q <= '0;
        end else if (load_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            p_q     <= '0;
            count_q <= '0;
        end else if (step_i) begin
            p_q     <= {sum_d, p_q[WIDTH-1:1]};
            b_q     <= b_q >> 1;
            count_q <= count_q + CW'(1);
        end
    end

    assign p_o         = p_q;
    assign last_step_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/maddu_sequencer.sv
// HI/LO multiply sequencer for MADDU/MULTU: control FSM, pipeline stall decode and
// the HI/LO registers with the accumulate adder.
module maddu_sequencer
    import maddu_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             acc_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o
);

    mul_state_e         state_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               acc_q;
    logic               done_q;
    logic               start_ok;
    logic               load;
    logic               step;
    logic               last_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc_sum_d;
    logic [2*WIDTH-1:0] commit_d;

    assign start_ok = start_i && !flush_i;
    assign load     = (state_q == ST_IDLE) && start_ok;
    assign step     = (state_q == ST_MUL);

    maddu_sequencer_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load),
        .step_i      (step),
        .a_i         (src_a_i),
        .b_i         (src_b_i),
        .p_o         (prod),
        .last_step_o (last_step)
    );

    // Accumulate wraps modulo 2^(2W); carry out of the top is dropped.
    assign acc_sum_d = {hi_q, lo_q} + prod;
    assign commit_d  = acc_q ? acc_sum_d : prod;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        acc_q   <= acc_i;
                        state_q <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (flush_i)        state_q <= ST_IDLE;
                    else if (last_step) state_q <= ST_ACC;
                end
                ST_ACC: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        {hi_q, lo_q} <= commit_d;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign stall_o = load || (state_q == ST_MUL) || (state_q == ST_ACC);

endmodule

// File: tb/tb_maddu_sequencer.sv
// Directed, table-driven bench for maddu_sequencer: chained overwrite/accumulate
// operations plus flush and mid-operation reset sequences.
module tb_maddu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        acc = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    maddu_sequencer #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .acc_i   (acc),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .flush_i (flush),
        .hi_o    (hi),
        .lo_o    (lo),
        .busy_o  (busy),
        .stall_o (stall),
        .done_o  (done)
    );

    typedef struct {
        logic        acc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one instruction at a negedge (cycle 0) and follows it to cycle 35.
    task automatic run_op(input string tag, input logic op_acc, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int stall_bad = 0;
        int done_cnt  = 0;
        int done_at   = -1;
        @(negedge clk);
        acc = op_acc; src_a = a; src_b = b; start = 1'b1;
        #1;
        for (int cyc = 0; cyc <= 35; cyc++) begin
            if (cyc == 1) begin
                src_a = ~a; src_b = ~b; acc = ~op_acc;
            end
            if (cyc == 35) begin
                start = 1'b0;
                #1;
            end
            if (stall !== (cyc <= 33)) stall_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
            if (cyc == 34) chk({tag, " result"}, {hi, lo}, exp);
            if (cyc == 35) chk({tag, " busy_after"}, 64'(busy), 64'd0);
            if (cyc < 35) begin
                @(negedge clk);
                #1;
            end
        end
        chk({tag, " stall_window_errs"}, 64'(stall_bad), 64'd0);
        chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, " done_cycle"}, 64'(done_at), 64'd34);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [63:0] saved;

        vecs[0] = '{1'b0, 32'd3,         32'd5,         64'h00000000_0000000F};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF};
        vecs[2] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFF_00000000};
        vecs[3] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
        vecs[4] = '{1'b1, 32'hFFFFFFFF,  32'd2,         64'hFFFFFFFF_FFFFFFFF};
        vecs[5] = '{1'b1, 32'd1,         32'd1,         64'h00000000_00000000};
        vecs[6] = '{1'b0, 32'h12345678,  32'd0,         64'h00000000_00000000};
        vecs[7] = '{1'b1, 32'h00010000,  32'h00010000,  64'h00000001_00000000};
        vecs[8] = '{1'b1, 32'hDEADBEEF,  32'd1,         64'h00000001_DEADBEEF};
        vecs[9] = '{1'b0, 32'h80000000,  32'h80000000,  64'h40000000_00000000};

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Flush in IDLE overrides start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; acc = 1'b0; src_a = 32'd9; src_b = 32'd9;
        #1;
        chk("idle_flush stall", 64'(stall), 64'd0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (busy !== 1'b0) n++;
        end
        chk("idle_flush busy_cycles", 64'(n), 64'd0);
        chk("idle_flush hilo", {hi, lo}, 64'h40000000_00000000);
        start = 1'b0; flush = 1'b0;

        // Flush during MUL
        saved = {hi, lo};
        @(negedge clk);
        start = 1'b1; acc = 1'b1; src_a = 32'd7; src_b = 32'd9;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        #1;
        chk("mul_flush stall_c10", 64'(stall), 64'd1);
        chk("mul_flush busy_c10", 64'(busy), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("mul_flush busy_c11", 64'(busy), 64'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) n++;
        end
        chk("mul_flush done_pulses", 64'(n), 64'd0);
        chk("mul_flush hilo", {hi, lo}, saved);
        run_op("post_flush", 1'b1, 32'd7, 32'd9, 64'h40000000_0000003F);

        // Reset in the middle of a MADDU
        @(negedge clk);
        start = 1'b1; acc = 1'b1; src_a = 32'd3; src_b = 32'd3;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst stall_c20", 64'(stall), 64'd1);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst stall", 64'(stall), 64'd0);
        chk("midrst hilo", {hi, lo}, 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        run_op("post_rst", 1'b1, 32'd3, 32'd5, 64'h00000000_0000000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
